// File: rtl/mini_cpu_pkg.sv
// +------------------------------------------------------------------+
// | mini_cpu_pkg: shared state, opcode/funct and ALU encodings for   |
// |               the multicycle controller.                         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package mini_cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_ADDR,
    S_MEM_RD,
    S_LD_WB,
    S_MEM_WR,
    S_EXEC,
    S_R_WB,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// +------------------------------------------------------------------+
// | alu_decoder: maps R-type funct3/funct7 to an alu_ctrl code and   |
// |              flags whether the combination is supported.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module alu_decoder
  import mini_cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
      alu_ctrl = ALU_ADD;
      legal    = 1'b1;
    end else if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
      alu_ctrl = ALU_SUB;
      legal    = 1'b1;
    end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
      alu_ctrl = ALU_AND;
      legal    = 1'b1;
    end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
      alu_ctrl = ALU_OR;
      legal    = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +------------------------------------------------------------------+
// | multicycle_control: FSM sequencing fetch/decode/execute for the  |
// |   mini CPU (ld, sd, beq, add/sub/and/or).                        |
// | Option: MINI_CPU_ILLEGAL_TRAP_EN - illegal opcodes halt the core |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module multicycle_control
  import mini_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        retire,
  output logic        illegal
);

`ifdef MINI_CPU_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t      state_q, state_d;
  logic [2:0]  rtype_alu_ctrl;
  logic        rtype_legal;
  logic        mem_ready_eff;
  logic [6:0]  opcode;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  // A completion seen while reset is held belongs to an abandoned request.
  assign mem_ready_eff     = mem_ready & ~rst;

  alu_decoder u_alu_decoder (
    .funct3   (instr[14:12]),
    .funct7   (instr[31:25]),
    .alu_ctrl (rtype_alu_ctrl),
    .legal    (rtype_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_ctrl   = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready_eff;
        pc_write  = mem_ready_eff;
        if (mem_ready_eff) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH: state_d = (instr[14:12] == F3_BEQ) ? S_BRANCH : ILLEGAL_NEXT;
          OP_RTYPE:  state_d = rtype_legal ? S_EXEC : ILLEGAL_NEXT;
          default:   state_d = ILLEGAL_NEXT;
        endcase
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready_eff) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        addr_sel  = 1'b1;
        retire    = mem_ready_eff;
        if (mem_ready_eff) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = rtype_alu_ctrl;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        // instr is stable until retire, so the decoder output is still valid.
        alu_ctrl  = rtype_alu_ctrl;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

`ifdef MINI_CPU_ILLEGAL_TRAP_EN
  // HALT is left only through reset, which makes the flag sticky.
  assign illegal = (state_q == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 instr  in  32  instruction register contents, stable from DECODE until retire.
REQ-005 mem_ready  in  1  memory completes the current request this cycle.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_req, mem_write, addr_sel  out  1 each  request, write strobe, address select (0=PC, 1=ALU result).
REQ-008 ir_write, pc_write, pc_src  out  1 each  IR load, PC load, PC source (0=PC+4, 1=branch target).
REQ-009 alu_src_a  out  1  (0=PC, 1=rs1); alu_src_b  out  2  (00=rs2, 01=const 4, 10=imm).
REQ-010 alu_ctrl  out  3  (010 add, 110 sub, 000 and, 001 or).
REQ-011 reg_write, mem_to_reg, retire, illegal  out  1 each.

Function
REQ-012 States SHALL be FETCH, DECODE, ADDR, MEM_RD, LD_WB, MEM_WR, EXEC, R_WB, BRANCH, HALT; outputs are Moore decodes of state except where conditioned on an input below.
REQ-013 FETCH: mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010; ir_write=pc_write=mem_ready, pc_src=0; stay until mem_ready, then DECODE.
REQ-014 DECODE (1 cycle): opcode 0000011 -> ADDR (ld); 0100011 -> ADDR (sd); 1100011 with funct3=000 -> BRANCH; 0110011 with legal funct -> EXEC; anything else is illegal.
REQ-015 ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=010; next MEM_RD for ld, MEM_WR for sd.
REQ-016 MEM_RD: mem_req=1, addr_sel=1, mem_write=0; hold until mem_ready, then LD_WB.
REQ-017 LD_WB: reg_write=1, mem_to_reg=1, retire=1; next FETCH.
REQ-018 MEM_WR: mem_req=1, mem_write=1, addr_sel=1; on mem_ready retire=1 and next FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct decode; next R_WB.
REQ-020 R_WB: reg_write=1, mem_to_reg=0, alu_ctrl held; retire=1; next FETCH.
REQ-021 R-type legal set: funct3=000 with funct7=0000000 gives 010 and 0100000 gives 110; funct3=111 or 110 with funct7=0000000 gives 000 or 001 respectively.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=1, pc_write=zero, retire=1; next FETCH.
REQ-023 Minimum latency with zero-wait memory: beq 3, add/sub/and/or 4, sd 4, ld 5 cycles, FETCH entry to retire inclusive.
REQ-024 mem_req and mem_write/addr_sel SHALL stay constant until mem_ready; mem_ready while mem_req=0 is ignored.
REQ-025 In every state, outputs not listed SHALL be 0, and alu_src_a, alu_src_b and alu_ctrl SHALL be 0, 00 and 010 respectively.
REQ-026 retire SHALL be a single-cycle pulse per completed instruction.

Reset
REQ-027 rst SHALL force FETCH immediately, including mid-request; all outputs take FETCH values with mem_ready treated as 0. An asserted rst therefore drives mem_req=1; a request aborted by rst is abandoned and re-issued after release.
REQ-028 FETCH SHALL be the first state after rst deasserts; illegal SHALL clear to 0.

Configuration
REQ-029 With MINI_CPU_ILLEGAL_TRAP_EN defined, an illegal DECODE SHALL enter HALT. HALT drives all enables to 0, sets sticky illegal=1 and is exited only by rst.
REQ-030 Without the macro, an illegal DECODE SHALL return to FETCH without retire, and illegal SHALL be tied to 0.

Structure
REQ-031 Package mini_cpu_pkg SHALL hold the state enum, opcode/funct constants, alu_ctrl codes and alu_src_b codes.
REQ-032 Sub-module alu_decoder SHALL map funct3/funct7 to alu_ctrl plus a legal flag.

Verification
REQ-033 0x003100b3 (add), mem_ready=1 -> 4 states, alu_ctrl=010 in EXEC, reg_write=1 and retire=1 in R_WB.
REQ-034 0x02813083 (ld), mem_ready low 3 cycles in MEM_RD -> mem_req, addr_sel held, then LD_WB with mem_to_reg=1 and retire at cycle 8.
REQ-035 0x02208463 (beq), zero=1 vs zero=0 -> pc_write=1/pc_src=1 vs pc_write=0; retire in both cases.
REQ-036 0x02113423 (sd) with rst asserted mid-MEM_WR -> asynchronous return to FETCH with mem_write=0, addr_sel=0, mem_req=1, no retire.
REQ-037 0xffffffff with macro -> HALT, illegal=1 until rst; without macro -> FETCH after DECODE, illegal=0.
